// File: rtl/injector_sequence_pkg.sv
// Shared definitions for the multi-channel injector start synchroniser:
// channel FSM encoding and the default power-line timeout.
package injector_sequence_pkg;

    typedef enum logic [1:0] {
        CH_IDLE            = 2'd0,
        CH_AWAIT_POWERLINE = 2'd1,
        CH_AWAIT_ALIGN     = 2'd2
    } chan_state_e;

    // 50 ms of evgTxClk at 50 MHz: no power-line edge for this long means the line is absent.
    localparam int DEFAULT_TIMEOUT_TICKS = 2500000;

endpackage

// File: rtl/injector_sequence_channel.sv
// One start channel: waits for a power-line edge (or timeout/bypass), then for its
// alignment phase, and emits a single-cycle sequencer start. Tracks dropped requests.
module injector_sequence_channel
    import injector_sequence_pkg::*;
#(
    parameter int ALIGN_WIDTH = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   enable_i,
    input  logic                   request_i,
    input  logic                   bypass_powerline_i,
    input  logic                   bypass_align_i,
    input  logic                   powerline_edge_i,
    input  logic                   powerline_timeout_i,
    input  logic                   overrun_clear_i,
    input  logic [ALIGN_WIDTH-1:0] offset_i,
    input  logic [ALIGN_WIDTH-1:0] align_count_i,
    output logic                   start_o,
    output logic                   overrun_o,
    output logic [1:0]             state_o
);

    chan_state_e state_q;
    logic        start_q;
    logic        overrun_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= CH_IDLE;
            start_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            start_q <= 1'b0;

            // A fresh overrun beats a simultaneous clear so no drop goes unreported.
            if (request_i && enable_i && (state_q != CH_IDLE)) begin
                overrun_q <= 1'b1;
            end else if (overrun_clear_i) begin
                overrun_q <= 1'b0;
            end

            if (!enable_i) begin
                state_q <= CH_IDLE;
            end else begin
                case (state_q)
                    CH_IDLE: begin
                        if (request_i) begin
                            state_q <= CH_AWAIT_POWERLINE;
                        end
                    end
                    CH_AWAIT_POWERLINE: begin
                        if (powerline_edge_i || powerline_timeout_i || bypass_powerline_i) begin
                            state_q <= CH_AWAIT_ALIGN;
                        end
                    end
                    CH_AWAIT_ALIGN: begin
                        if (bypass_align_i || (align_count_i == offset_i)) begin
                            state_q <= CH_IDLE;
                            start_q <= 1'b1;
                        end
                    end
                    default: state_q <= CH_IDLE;
                endcase
            end
        end
    end

    assign start_o   = start_q;
    assign overrun_o = overrun_q;
    assign state_o   = state_q;

endmodule

// File: rtl/injector_sequence_sync.sv
// Multi-channel injector start synchroniser in the EVG transmit clock domain: shared
// alignment counter, power-line edge/timeout detection, and one FSM per channel.
module injector_sequence_sync
    import injector_sequence_pkg::*;
#(
    parameter int CHANNEL_COUNT           = 4,
    parameter int ALIGN_WIDTH             = 16,
    parameter int POWERLINE_TIMEOUT_TICKS = DEFAULT_TIMEOUT_TICKS,
    parameter int TIMEOUT_WIDTH           = $clog2(POWERLINE_TIMEOUT_TICKS + 1)
) (
    input  logic                               evgTxClk,
    input  logic                               evgTxRst_n,
    input  logic                               evgHeartbeat,
    input  logic                               powerline,
    input  logic [ALIGN_WIDTH-1:0]             alignPeriod,
    input  logic [CHANNEL_COUNT-1:0]           chanEnable,
    input  logic [CHANNEL_COUNT-1:0]           chanBypassPowerline,
    input  logic [CHANNEL_COUNT-1:0]           chanBypassAlign,
    input  logic [CHANNEL_COUNT*ALIGN_WIDTH-1:0] chanOffset,
    input  logic [CHANNEL_COUNT-1:0]           chanRequest,
    input  logic                               overrunClear,
    output logic [CHANNEL_COUNT-1:0]           sequenceStart,
    output logic [CHANNEL_COUNT-1:0]           chanBusy,
    output logic [CHANNEL_COUNT-1:0]           chanOverrun,
    output logic                               alignmentSynced,
    output logic                               powerlineTimeout
);

    localparam logic [ALIGN_WIDTH-1:0]   ALIGN_ONE     = ALIGN_WIDTH'(1);
    localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_ONE   = TIMEOUT_WIDTH'(1);
    localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LIMIT = TIMEOUT_WIDTH'(POWERLINE_TIMEOUT_TICKS);

    logic [ALIGN_WIDTH-1:0]   align_cnt_q, align_cnt_d;
    logic                     synced_q;
    logic                     powerline_q;
    logic [TIMEOUT_WIDTH-1:0] timeout_cnt_q, timeout_cnt_d;
    logic                     timeout_q;
    logic                     powerline_edge;
    logic                     period_short;
    logic [ALIGN_WIDTH-1:0]   period_last;
    logic [CHANNEL_COUNT-1:0][1:0] chan_state;

    assign powerline_edge = powerline & ~powerline_q;
    assign period_short   = (alignPeriod <= ALIGN_ONE);
    assign period_last    = alignPeriod - ALIGN_ONE;

    // The >= wrap keeps the counter in range if the period is reprogrammed smaller.
    always_comb begin
        align_cnt_d = align_cnt_q + ALIGN_ONE;
        if (evgHeartbeat || period_short || (align_cnt_q >= period_last)) begin
            align_cnt_d = '0;
        end
    end

    always_comb begin
        timeout_cnt_d = timeout_cnt_q + TIMEOUT_ONE;
        if (powerline_edge) begin
            timeout_cnt_d = '0;
        end else if (timeout_cnt_q >= TIMEOUT_LIMIT) begin
            timeout_cnt_d = timeout_cnt_q;
        end
    end

    always_ff @(posedge evgTxClk or negedge evgTxRst_n) begin
        if (!evgTxRst_n) begin
            align_cnt_q   <= '0;
            synced_q      <= 1'b0;
            powerline_q   <= 1'b0;
            timeout_cnt_q <= '0;
            timeout_q     <= 1'b0;
        end else begin
            align_cnt_q   <= align_cnt_d;
            powerline_q   <= powerline;
            timeout_cnt_q <= timeout_cnt_d;
            timeout_q     <= (timeout_cnt_d >= TIMEOUT_LIMIT);
            if (evgHeartbeat) begin
                synced_q <= period_short | (align_cnt_q == period_last);
            end
        end
    end

    for (genvar c = 0; c < CHANNEL_COUNT; c++) begin : g_chan
        injector_sequence_channel #(
            .ALIGN_WIDTH(ALIGN_WIDTH)
        ) u_chan (
            .clk_i               (evgTxClk),
            .rst_ni              (evgTxRst_n),
            .enable_i            (chanEnable[c]),
            .request_i           (chanRequest[c]),
            .bypass_powerline_i  (chanBypassPowerline[c]),
            .bypass_align_i      (chanBypassAlign[c]),
            .powerline_edge_i    (powerline_edge),
            .powerline_timeout_i (timeout_q),
            .overrun_clear_i     (overrunClear),
            .offset_i            (chanOffset[c*ALIGN_WIDTH +: ALIGN_WIDTH]),
            .align_count_i       (align_cnt_q),
            .start_o             (sequenceStart[c]),
            .overrun_o           (chanOverrun[c]),
            .state_o             (chan_state[c])
        );

        assign chanBusy[c] = (chan_state[c] != CH_IDLE);
    end

    assign alignmentSynced  = synced_q;
    assign powerlineTimeout = timeout_q;

endmodule
